tb_scheduler: RTL and testbench

- Sequences the Viterbi survivor memory and the traceback unit.
- Admits one trellis step at a time from the ACS/survivor-write stage.
- Once D steps are buffered, launches one fixed-depth traceback per step, using the best-metric state as the end state (or state 0 once the frame is terminated).
- At frame end, requests D-1 erasure flush steps so every info bit is decoded, strips the M tail bits, and emits a framed decoded-bit stream.

---
 rtl/tb_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tb_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_scheduler.sv
// Viterbi traceback scheduler: admits trellis steps, launches one traceback per
// buffered step, flushes D-1 erasure steps at frame end and strips the M tail bits.
module tb_scheduler #(
  parameter  int M  = 6,
  parameter  int D  = 40,
  parameter  int FW = 16,
  localparam int PW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_valid,
  output logic          step_ready,
  input  logic          step_last,
  input  logic [PW-1:0] wr_ptr,
  input  logic [M-1:0]  best_state,
  output logic          flush_step,
  output logic          tb_start,
  output logic [PW-1:0] tb_wr_ptr,
  output logic [M-1:0]  tb_s_end,
  input  logic          tb_dec_valid,
  input  logic          tb_dec_bit,
  output logic          out_valid,
  output logic          out_bit,
  output logic          out_last,
  output logic          busy,
  output logic          err
);

  localparam int FILLW = $clog2(D + 1);

  typedef enum logic [1:0] {ST_ACCEPT, ST_LAUNCH, ST_WAIT} state_e;

  state_e          state_q, state_d;
  logic [FILLW-1:0] fill_q, fill_d, fill_inc;
  logic [FW-1:0]   step_cnt_q, step_cnt_d;
  logic [FW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [FW:0]     n_q, n_d;
  logic            flushing_q, flushing_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [M-1:0]    best_q, best_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;

  // Bit index plus tail length, compared against the latched frame length N.
  logic [FW+1:0] k_plus_m, n_ext, n_new;

  assign k_plus_m = {2'b00, bit_cnt_q} + (FW+2)'(M);
  assign n_ext    = {1'b0, n_q};
  assign n_new    = {2'b00, step_cnt_q} + (FW+2)'(1);
  assign fill_inc = (fill_q == FILLW'(D)) ? fill_q : fill_q + FILLW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCEPT;
      fill_q      <= '0;
      step_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      flush_cnt_q <= '0;
      n_q         <= '0;
      flushing_q  <= 1'b0;
      wr_ptr_q    <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      step_cnt_q  <= step_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      n_q         <= n_d;
      flushing_q  <= flushing_d;
      wr_ptr_q    <= wr_ptr_d;
      best_q      <= best_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    step_cnt_d  = step_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    flush_cnt_d = flush_cnt_q;
    n_d         = n_q;
    flushing_d  = flushing_q;
    wr_ptr_d    = wr_ptr_q;
    best_d      = best_q;
    out_valid_d = 1'b0;
    out_bit_d   = 1'b0;
    out_last_d  = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      ST_ACCEPT: begin
        if (tb_dec_valid) err_d = 1'b1;
        if (step_valid) begin
          wr_ptr_d = wr_ptr;
          best_d   = best_state;
          fill_d   = fill_inc;
          if (flushing_q) begin
            flush_cnt_d = flush_cnt_q + PW'(1);
          end else begin
            if (step_cnt_q == '1) err_d = 1'b1;
            else                  step_cnt_d = step_cnt_q + FW'(1);
            if (step_last) begin
              n_d        = n_new[FW:0];
              flushing_d = 1'b1;
              if (n_new <= (FW+2)'(M)) err_d = 1'b1;
            end
          end
          if (fill_inc == FILLW'(D)) state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (tb_dec_valid) err_d = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (tb_dec_valid) begin
          // Once N is known, indices at or beyond N-M are tail bits.
          if (!(flushing_q && (k_plus_m >= n_ext))) begin
            out_valid_d = 1'b1;
            out_bit_d   = tb_dec_bit;
            out_last_d  = flushing_q && (k_plus_m + (FW+2)'(1) == n_ext);
          end
          bit_cnt_d = bit_cnt_q + FW'(1);
          state_d   = ST_ACCEPT;
          if (flushing_q && (flush_cnt_q == PW'(D - 1))) begin
            fill_d      = '0;
            step_cnt_d  = '0;
            bit_cnt_d   = '0;
            flush_cnt_d = '0;
            flushing_d  = 1'b0;
          end
        end
      end

      default: state_d = ST_ACCEPT;
    endcase
  end

  always_comb begin
    step_ready = (state_q == ST_ACCEPT) && !rst;
    flush_step = step_ready && flushing_q;
    tb_start   = (state_q == ST_LAUNCH);
    tb_wr_ptr  = tb_start ? wr_ptr_q : '0;
    // Terminated frames end in state 0; the step_last launch already sees flushing.
    tb_s_end   = (tb_start && !flushing_q) ? best_q : '0;
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign busy      = (fill_q != '0) || flushing_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tb_scheduler.sv
// Randomized bench for tb_scheduler: an ACS driver and traceback responder are
// checked against a frame-level model of launches, end states and output bits.
module tb_tb_scheduler;

  localparam int M  = 3;
  localparam int D  = 8;
  localparam int FW = 16;
  localparam int PW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          step_valid, step_ready, step_last;
  logic [PW-1:0] wr_ptr, tb_wr_ptr;
  logic [M-1:0]  best_state, tb_s_end;
  logic          flush_step, tb_start, tb_dec_valid, tb_dec_bit;
  logic          out_valid, out_bit, out_last, busy, err;

  int total = 0;
  int bad   = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  tb_scheduler #(.M(M), .D(D), .FW(FW)) dut (
    .clk(clk), .rst(rst),
    .step_valid(step_valid), .step_ready(step_ready), .step_last(step_last),
    .wr_ptr(wr_ptr), .best_state(best_state), .flush_step(flush_step),
    .tb_start(tb_start), .tb_wr_ptr(tb_wr_ptr), .tb_s_end(tb_s_end),
    .tb_dec_valid(tb_dec_valid), .tb_dec_bit(tb_dec_bit),
    .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .busy(busy), .err(err)
  );

  // Runs one frame of n info+tail steps. Launch j (0-based step index j>=D-1)
  // must carry that step's column, and best_state only while j < n-1.
  // Decoded bit k is emitted iff k < n-M, with out_last at k == n-M-1.
  task automatic run_frame(input int n, input bit hold, input int abort_launch);
    int acc, norm, fl, launches, decs, outs, cd, kprev, idx;
    bit hs_prev, hs_norm, dec_prev, pend, frame_end, exp_start, exp_ov, aborted, have;
    bit bitprev, exp_fl, exp_busy;
    logic [PW-1:0] cur_ptr;
    logic [M-1:0]  cur_best, exp_s;
    logic [PW-1:0] ptrs[$];
    logic [M-1:0]  bests[$];
    acc = 0; norm = 0; fl = 0; launches = 0; decs = 0; outs = 0; cd = 0; kprev = 0;
    hs_prev = 0; hs_norm = 0; dec_prev = 0; pend = 0; frame_end = 0; aborted = 0;
    bitprev = 0;
    cur_ptr  = PW'($urandom_range(0, D - 1));
    cur_best = M'($urandom);
    for (int cyc = 0; cyc < 4000 && !frame_end && !aborted; cyc++) begin
      @(negedge clk);
      if (hs_prev) begin
        acc++;
        if (hs_norm) norm++;
        else         fl++;
      end
      exp_ov = 1'b0;
      if (dec_prev) begin
        pend   = 1'b0;
        exp_ov = (kprev < n - M);
        if (kprev == n - 1) frame_end = 1'b1;
      end
      exp_start = hs_prev && (acc >= D);
      hs_prev = 1'b0;
      dec_prev = 1'b0;

      total++;
      if (tb_start !== exp_start) begin
        bad++;
        $display("FAIL launch n=%0d step=%0d: tb_start=%b want %b", n, acc, tb_start, exp_start);
      end
      if (exp_start) begin
        pend  = 1'b1;
        idx   = acc - 1;
        exp_s = (idx < n - 1) ? bests[idx] : '0;
        total++;
        if (tb_wr_ptr !== ptrs[idx]) begin
          bad++;
          $display("FAIL tb_wr_ptr step=%0d: got %0d want %0d", idx, tb_wr_ptr, ptrs[idx]);
        end
        total++;
        if (tb_s_end !== exp_s) begin
          bad++;
          $display("FAIL tb_s_end step=%0d: got %0d want %0d", idx, tb_s_end, exp_s);
        end
        launches++;
        cd = $urandom_range(1, 3);
      end
      total++;
      if (step_ready !== !pend) begin
        bad++;
        $display("FAIL step_ready n=%0d: got %b want %b", n, step_ready, !pend);
      end
      exp_busy = (acc > 0) && !frame_end;
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy n=%0d: got %b want %b", n, busy, exp_busy);
      end
      exp_fl = (norm == n) && !pend && !frame_end;
      total++;
      if (flush_step !== exp_fl) begin
        bad++;
        $display("FAIL flush_step n=%0d: got %b want %b", n, flush_step, exp_fl);
      end
      total++;
      if (out_valid !== exp_ov) begin
        bad++;
        $display("FAIL out_valid n=%0d k=%0d: got %b want %b", n, kprev, out_valid, exp_ov);
      end
      if (exp_ov) begin
        outs++;
        total++;
        if (out_bit !== bitprev) begin
          bad++;
          $display("FAIL out_bit k=%0d: got %b want %b", kprev, out_bit, bitprev);
        end
        total++;
        if (out_last !== (kprev == n - M - 1)) begin
          bad++;
          $display("FAIL out_last k=%0d: got %b want %b", kprev, out_last, kprev == n - M - 1);
        end
      end

      if (abort_launch >= 0 && launches == abort_launch && pend && !exp_start) begin
        rst = 1'b1;
        step_valid = 1'b0;
        tb_dec_valid = 1'b0;
        aborted = 1'b1;
      end else begin
        tb_dec_valid = 1'b0;
        tb_dec_bit   = 1'b0;
        if (pend && !exp_start) begin
          cd--;
          if (cd == 0) begin
            tb_dec_valid = 1'b1;
            tb_dec_bit   = 1'($urandom_range(0, 1));
            dec_prev = 1'b1;
            kprev    = decs;
            bitprev  = tb_dec_bit;
            decs++;
          end
        end
        have = (norm < n) || (fl < D - 1);
        step_valid = 1'b0;
        step_last  = 1'b0;
        if (have && (hold || $urandom_range(0, 3) != 0)) begin
          step_valid = 1'b1;
          wr_ptr     = cur_ptr;
          best_state = cur_best;
          step_last  = (norm < n) ? (norm == n - 1) : 1'($urandom_range(0, 1));
          if (step_ready) begin
            hs_prev = 1'b1;
            hs_norm = (norm < n);
            ptrs.push_back(cur_ptr);
            bests.push_back(cur_best);
            cur_ptr  = PW'($urandom_range(0, D - 1));
            cur_best = M'($urandom);
          end
        end else if (!step_ready && $urandom_range(0, 1) == 1) begin
          step_valid = 1'b1;
          step_last  = 1'b1;
          wr_ptr     = PW'($urandom_range(0, D - 1));
          best_state = M'($urandom);
        end
      end
    end
    step_valid   = 1'b0;
    step_last    = 1'b0;
    tb_dec_valid = 1'b0;
    if (!aborted) begin
      total++;
      if (!frame_end) begin
        bad++;
        $display("FAIL frame_timeout n=%0d: launches=%0d decs=%0d", n, launches, decs);
      end
      total++;
      if (launches != n) begin
        bad++;
        $display("FAIL launch_count n=%0d: got %0d want %0d", n, launches, n);
      end
      total++;
      if (outs != ((n > M) ? n - M : 0)) begin
        bad++;
        $display("FAIL out_count n=%0d: got %0d want %0d", n, outs, (n > M) ? n - M : 0);
      end
      total++;
      if (fl != D - 1) begin
        bad++;
        $display("FAIL flush_count n=%0d: got %0d want %0d", n, fl, D - 1);
      end
      if (n <= M) exp_err = 1'b1;
      total++;
      if (err !== exp_err) begin
        bad++;
        $display("FAIL err_after_frame n=%0d: got %b want %b", n, err, exp_err);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [15:0] flat;
    flat = {step_ready, flush_step, tb_start, tb_wr_ptr, tb_s_end,
            out_valid, out_bit, out_last, busy, err};
    total++;
    if (flat !== '0) begin
      bad++;
      $display("FAIL %s outputs: got %h want 0", tag, flat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step_valid = 1'b0; step_last = 1'b0; wr_ptr = '0; best_state = '0;
    tb_dec_valid = 1'b0; tb_dec_bit = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    total++;
    if (step_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: ready=%b busy=%b err=%b want 1 0 0", step_ready, busy, err);
    end
  endtask

  task automatic test_long_frame();
    run_frame(20, 1'b0, -1);
  endtask

  task automatic test_short_frame();
    run_frame(5, 1'b0, -1);
  endtask

  task automatic test_spurious();
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL spurious_pre err: got %b want 0", err);
    end
    tb_dec_valid = 1'b1;
    tb_dec_bit   = 1'b1;
    @(negedge clk);
    tb_dec_valid = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b0 || err !== 1'b1) begin
        bad++;
        $display("FAIL spurious cycle=%0d: out_valid=%b err=%b want 0 1", i, out_valid, err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    run_frame(20, 1'b0, 2);
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    exp_err = 1'b0;
    run_frame(10, 1'b0, -1);
  endtask

  task automatic test_tiny_frame();
    run_frame(3, 1'b0, -1);
    run_frame(12, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_frame(15, 1'b1, -1);
    run_frame(9, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_short_frame();
    test_spurious();
    test_mid_reset();
    test_tiny_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
